// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin sharing of one external pipelined signed multiplier among
// REQ_N requesters. At most one operand pair is issued per clock. A tag pipe
// of MUL_LATENCY stages runs in lock-step with the multiplier enables, so
// each product is returned to its issuing requester with its info tag.
// aclken low freezes the arbiter, the tag pipe and the multiplier together.

module mul_share_arbiter #(
  parameter int REQ_N       = 2,
  parameter int OP_W        = 32,
  parameter int RES_W       = 64,
  parameter int INFO_W      = 2,
  parameter int MUL_LATENCY = 3,
  parameter int SIM_DELAY   = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      aclken,
  input  logic [REQ_N*OP_W-1:0]     req_op_a,
  input  logic [REQ_N*OP_W-1:0]     req_op_b,
  input  logic [REQ_N*INFO_W-1:0]   req_info,
  input  logic [REQ_N-1:0]          req_vld,
  output logic [REQ_N-1:0]          req_rdy,
  output logic [RES_W-1:0]          res,
  output logic [INFO_W-1:0]         res_info,
  output logic [REQ_N-1:0]          res_vld,
  output logic                      mul_clk,
  output logic [OP_W-1:0]           mul_op_a,
  output logic [OP_W-1:0]           mul_op_b,
  output logic [2:0]                mul_ce,
  input  logic [RES_W-1:0]          mul_res
);

  localparam int ID_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  // Register updates carry no delay in RTL; SIM_DELAY only has to be sane.
  if (REQ_N < 2 || REQ_N > 4 || RES_W != 2 * OP_W || MUL_LATENCY < 1 || SIM_DELAY < 0)
  begin : g_param_check
    $error("mul_share_arbiter: unsupported parameter combination");
  end

  // Round-robin pointer: index of the most recently granted requester.
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Last issued operands, held on the multiplier inputs while idle.
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;

  // Tag pipe, one entry per enabled multiplier register stage.
  logic [MUL_LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [MUL_LATENCY-1:0][ID_W-1:0]   tag_id_q, tag_id_d;
  logic [MUL_LATENCY-1:0][INFO_W-1:0] tag_info_q, tag_info_d;

  // Arbitration results.
  logic [REQ_N-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [ID_W-1:0]   scan_id;
  logic              handshake;

  // Granted slot contents.
  logic [OP_W-1:0]   sel_a;
  logic [OP_W-1:0]   sel_b;
  logic [INFO_W-1:0] sel_info;

  // Scan from ptr+1 upward and grant the first valid requester.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_id   = '0;
    if (aclken) begin
      for (int k = 1; k <= REQ_N; k++) begin
        scan_id = ID_W'((int'(ptr_q) + k) % REQ_N);
        if (!grant_any && req_vld[scan_id]) begin
          grant_any         = 1'b1;
          grant_oh[scan_id] = 1'b1;
          grant_id          = scan_id;
        end
      end
    end
  end

  assign req_rdy   = grant_oh;
  assign handshake = |(req_vld & grant_oh);

  // Select the granted slot and compute next pointer / held operands.
  always_comb begin
    sel_a    = req_op_a[int'(grant_id) * OP_W +: OP_W];
    sel_b    = req_op_b[int'(grant_id) * OP_W +: OP_W];
    sel_info = req_info[int'(grant_id) * INFO_W +: INFO_W];
    ptr_d    = ptr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    if (handshake) begin
      ptr_d  = grant_id;
      op_a_d = sel_a;
      op_b_d = sel_b;
    end
  end

  // Advance the tag pipe only when the multiplier pipe advances; empty slots move too.
  always_comb begin
    tag_vld_d  = tag_vld_q;
    tag_id_d   = tag_id_q;
    tag_info_d = tag_info_q;
    if (aclken) begin
      tag_vld_d[0]  = handshake;
      tag_id_d[0]   = grant_id;
      tag_info_d[0] = sel_info;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_vld_d[k]  = tag_vld_q[k-1];
        tag_id_d[k]   = tag_id_q[k-1];
        tag_info_d[k] = tag_info_q[k-1];
      end
    end
  end

  // State registers with synchronous active-low reset; reset drops in-flight ops.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q      <= ID_W'(REQ_N - 1);
      op_a_q     <= '0;
      op_b_q     <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      tag_info_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      tag_info_q <= tag_info_d;
    end
  end

  // Route the completing product to its requester; nothing completes while frozen.
  always_comb begin
    res_vld = '0;
    for (int i = 0; i < REQ_N; i++) begin
      res_vld[i] = tag_vld_q[MUL_LATENCY-1] & aclken &
                   (tag_id_q[MUL_LATENCY-1] == ID_W'(i));
    end
  end

  assign res      = mul_res;
  assign res_info = tag_info_q[MUL_LATENCY-1];
  assign mul_clk  = aclk;
  assign mul_op_a = op_a_d;
  assign mul_op_b = op_b_d;
  assign mul_ce   = {3{aclken}};

endmodule
